game_flow_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 18 +
 rtl/sync_edge.sv | 18 +
 rtl/game_flow_ctrl.sv | 127 ++++++++++++
 tb/tb_game_flow_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: state encoding, winner codes and default timing for the round sequencer.
package game_pkg;
  typedef enum logic [2:0] {
    MENU     = 3'd0,
    PLAY     = 3'd1,
    DYING    = 3'd2,
    GAMEOVER = 3'd3,
    CLEAR    = 3'd4
  } state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  localparam int DEF_STEP_TICKS   = 5;
  localparam int DEF_ANIM_STEPS   = 5;
  localparam int DEF_GO_MIN_TICKS = 60;
  localparam int DEF_CLR_TICKS    = 2;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer plus registered rising-edge pulse (3 cycles raw edge to pulse).
module sync_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic pulse
);
  logic [2:0] sr;
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sr    <= '0;
      pulse <= 1'b0;
    end else begin
      sr    <= {sr[1:0], din};
      pulse <= sr[1] & ~sr[2];
    end
  end
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: round sequencer (menu, play, death animation, game over, round clear).
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int STEP_TICKS   = DEF_STEP_TICKS,
  parameter int ANIM_STEPS   = DEF_ANIM_STEPS,
  parameter int GO_MIN_TICKS = DEF_GO_MIN_TICKS,
  parameter int CLR_TICKS    = DEF_CLR_TICKS
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_btn,
  input  logic       restart_btn,
  input  logic       tank1_alive,
  input  logic       tank2_alive,
  output logic [2:0] state_o,
  output logic       play_en,
  output logic       dying1,
  output logic       dying2,
  output logic [2:0] anim_step,
  output logic [1:0] winner,
  output logic       round_reset
);
  localparam int SW = $clog2(STEP_TICKS + 1);
  localparam int GW = $clog2(GO_MIN_TICKS + 1);
  localparam int CW = $clog2(CLR_TICKS + 1);
  logic tick, start_p, restart_p;
  state_t state, state_n;
  logic play_n, d1_n, d2_n, rr_n;
  logic [2:0] anim_n;
  logic [1:0] win_n;
  logic [SW-1:0] step_cnt, step_n;
  logic [GW-1:0] go_cnt, go_n;
  logic [CW-1:0] clr_cnt, clr_n;

  sync_edge u_tick    (.Clk(Clk), .Reset(Reset), .din(frame_clk),   .pulse(tick));
  sync_edge u_start   (.Clk(Clk), .Reset(Reset), .din(start_btn),   .pulse(start_p));
  sync_edge u_restart (.Clk(Clk), .Reset(Reset), .din(restart_btn), .pulse(restart_p));

  assign state_o = state;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= MENU;
      play_en     <= 1'b0;
      dying1      <= 1'b0;
      dying2      <= 1'b0;
      anim_step   <= '0;
      winner      <= WIN_NONE;
      round_reset <= 1'b0;
      step_cnt    <= '0;
      go_cnt      <= '0;
      clr_cnt     <= '0;
    end else begin
      state       <= state_n;
      play_en     <= play_n;
      dying1      <= d1_n;
      dying2      <= d2_n;
      anim_step   <= anim_n;
      winner      <= win_n;
      round_reset <= rr_n;
      step_cnt    <= step_n;
      go_cnt      <= go_n;
      clr_cnt     <= clr_n;
    end
  end

  always_comb begin
    state_n = state;
    play_n  = play_en;
    d1_n    = dying1;
    d2_n    = dying2;
    anim_n  = anim_step;
    win_n   = winner;
    rr_n    = round_reset;
    step_n  = step_cnt;
    go_n    = go_cnt;
    clr_n   = clr_cnt;
    case (state)
      MENU: if (start_p) begin
        state_n = PLAY;
        play_n  = 1'b1;
      end
      PLAY: if (!tank1_alive || !tank2_alive) begin
        state_n = DYING;
        play_n  = 1'b0;
        d1_n    = !tank1_alive;
        d2_n    = !tank2_alive;
        win_n   = (!tank1_alive && !tank2_alive) ? WIN_DRAW : !tank1_alive ? WIN_P2 : WIN_P1;
        anim_n  = '0;
        step_n  = '0;
      end
      DYING: if (tick) begin
        if (anim_step == 3'(ANIM_STEPS)) begin
          state_n = GAMEOVER;
          go_n    = '0;
        end else if (step_cnt == SW'(STEP_TICKS - 1)) begin
          step_n = '0;
          anim_n = anim_step + 3'd1;
        end else
          step_n = step_cnt + SW'(1);
      end
      GAMEOVER: begin
        if (tick && go_cnt != GW'(GO_MIN_TICKS)) go_n = go_cnt + GW'(1);
        // restart is only honoured once the screen has been held long enough; earlier presses are lost
        if (restart_p && go_cnt == GW'(GO_MIN_TICKS)) begin
          state_n = CLEAR;
          rr_n    = 1'b1;
          clr_n   = '0;
        end
      end
      CLEAR: if (tick) begin
        if (clr_cnt == CW'(CLR_TICKS - 1)) begin
          state_n = MENU;
          rr_n    = 1'b0;
          d1_n    = 1'b0;
          d2_n    = 1'b0;
          win_n   = WIN_NONE;
          anim_n  = '0;
        end else
          clr_n = clr_cnt + CW'(1);
      end
      default: state_n = MENU;
    endcase
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: randomized round scenarios checked against a tick-counting reference model.
module tb_game_flow_ctrl;
  import game_pkg::*;
  localparam int ST = 5, AS = 5, GO = 60, CT = 2;
  logic Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0, start_btn = 1'b0, restart_btn = 1'b0;
  logic tank1_alive = 1'b1, tank2_alive = 1'b1;
  logic [2:0] state_o, anim_step;
  logic [1:0] winner;
  logic play_en, dying1, dying2, round_reset;
  logic [11:0] ob;
  int nvec = 0, nerr = 0;

  game_flow_ctrl #(.STEP_TICKS(ST), .ANIM_STEPS(AS), .GO_MIN_TICKS(GO), .CLR_TICKS(CT)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_btn(start_btn),
    .restart_btn(restart_btn), .tank1_alive(tank1_alive), .tank2_alive(tank2_alive),
    .state_o(state_o), .play_en(play_en), .dying1(dying1), .dying2(dying2),
    .anim_step(anim_step), .winner(winner), .round_reset(round_reset)
  );

  always #10 Clk = ~Clk;
  assign ob = {state_o, play_en, dying1, dying2, anim_step, winner, round_reset};

  function automatic logic [11:0] ev(int s, int p, int d1, int d2, int a, int w, int r);
    return {3'(s), 1'(p), 1'(d1), 1'(d2), 3'(a), 2'(w), 1'(r)};
  endfunction

  function automatic int exp_win(bit d1, bit d2);
    return (d1 && d2) ? 3 : d1 ? 2 : 1;
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_clk = 1'b1;
    cyc(4);
    frame_clk = 1'b0;
    cyc($urandom_range(1, 3));
  endtask

  task automatic test_reset();
    logic [11:0] e;
    Reset = 1'b0;
    cyc(2);
    e = ev(0, 0, 0, 0, 0, 0, 0);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL reset_state got %h want %h", ob, e); end
    Reset = 1'b1;
    cyc(1);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL reset_release got %h want %h", ob, e); end
  endtask

  task automatic test_menu_alive();
    logic [11:0] e;
    tank1_alive = 1'b0;
    cyc(10);
    e = ev(0, 0, 0, 0, 0, 0, 0);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL menu_ignores_alive got %h want %h", ob, e); end
    tank1_alive = 1'b1;
    cyc(1);
  endtask

  task automatic test_round(input int mode, input bit late);
    bit d1, d2;
    int w, a, rg;
    logic [11:0] e;
    d1 = (mode != 1);
    d2 = (mode != 0);
    w = exp_win(d1, d2);
    rg = $urandom_range(5, 59);
    start_btn = 1'b1;
    cyc(3);
    e = ev(0, 0, 0, 0, 0, 0, 0);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL start_lat3 got %h want %h", ob, e); end
    cyc(1);
    e = ev(1, 1, 0, 0, 0, 0, 0);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL start_lat4 got %h want %h", ob, e); end
    start_btn = 1'b0;
    cyc($urandom_range(0, 6));
    nvec++; if (ob !== e) begin nerr++; $display("FAIL play_hold got %h want %h", ob, e); end
    tank1_alive = !d1;
    tank2_alive = !d2;
    cyc(1);
    e = ev(2, 0, d1, d2, 0, w, 0);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL dying_entry got %h want %h", ob, e); end
    for (int n = 1; n <= ST * AS + 1; n++) begin
      if (late && n == 3) begin tank1_alive = 1'b0; tank2_alive = 1'b0; end
      if (n == 7) begin start_btn = 1'b1; restart_btn = 1'b1; end
      if (n == 9) begin start_btn = 1'b0; restart_btn = 1'b0; end
      tick();
      a = (n / ST > AS) ? AS : n / ST;
      e = ev((n <= ST * AS) ? 2 : 3, 0, d1, d2, a, w, 0);
      nvec++; if (ob !== e) begin nerr++; $display("FAIL dying_tick%0d got %h want %h", n, ob, e); end
    end
    e = ev(3, 0, d1, d2, AS, w, 0);
    for (int g = 1; g <= GO; g++) begin
      tick();
      if (g == 4 || g == rg) begin
        restart_btn = 1'b1;
        cyc(4);
        restart_btn = 1'b0;
        cyc(1);
        nvec++; if (ob !== e) begin nerr++; $display("FAIL early_restart_g%0d got %h want %h", g, ob, e); end
      end
      if (g == 20) begin
        start_btn = 1'b1;
        cyc(4);
        start_btn = 1'b0;
        cyc(1);
        nvec++; if (ob !== e) begin nerr++; $display("FAIL gameover_start got %h want %h", ob, e); end
      end
    end
    restart_btn = 1'b1;
    cyc(3);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL restart_lat3 got %h want %h", ob, e); end
    cyc(1);
    e = ev(4, 0, d1, d2, AS, w, 1);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL restart_accept got %h want %h", ob, e); end
    restart_btn = 1'b0;
    tank1_alive = 1'b1;
    tank2_alive = 1'b1;
    for (int c = 1; c <= CT; c++) begin
      tick();
      e = (c < CT) ? ev(4, 0, d1, d2, AS, w, 1) : ev(0, 0, 0, 0, 0, 0, 0);
      nvec++; if (ob !== e) begin nerr++; $display("FAIL clear_tick%0d got %h want %h", c, ob, e); end
    end
  endtask

  task automatic test_frozen();
    logic [11:0] e;
    start_btn = 1'b1;
    cyc(4);
    start_btn = 1'b0;
    tank1_alive = 1'b0;
    cyc(1);
    repeat (7) tick();
    e = ev(2, 0, 1, 0, 1, 2, 0);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL frozen_pre got %h want %h", ob, e); end
    cyc(200);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL frozen_low got %h want %h", ob, e); end
    frame_clk = 1'b1;
    cyc(200);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL frozen_high got %h want %h", ob, e); end
    frame_clk = 1'b0;
    tank1_alive = 1'b1;
    cyc(2);
    Reset = 1'b0;
    cyc(1);
    Reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    start_btn = 1'b1;
    cyc(4);
    start_btn = 1'b0;
    tank2_alive = 1'b0;
    cyc(1);
    repeat (3 * ST) tick();
    e = ev(2, 0, 0, 1, 3, 1, 0);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL mid_anim3 got %h want %h", ob, e); end
    tank2_alive = 1'b1;
    Reset = 1'b0;
    cyc(1);
    e = ev(0, 0, 0, 0, 0, 0, 0);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL mid_reset got %h want %h", ob, e); end
    Reset = 1'b1;
    cyc(5);
    nvec++; if (ob !== e) begin nerr++; $display("FAIL mid_reset_after got %h want %h", ob, e); end
  endtask

  initial begin
    cyc(3);
    test_reset();
    test_menu_alive();
    test_round(0, 1'b1);
    test_round(1, 1'b0);
    test_round(2, 1'b0);
    repeat (2) test_round(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    test_frozen();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
